// File: rtl/aes_encrypt_iter.sv
// Iterative AES encryption core: one cipher round per clock over an externally expanded key schedule.
module aes_encrypt_iter #(
  parameter int unsigned nk = 4,
  parameter int unsigned nr = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [127:0]            state_in,
  input  logic [0:((nr+1)*128)-1] w,
  output logic                    busy,
  output logic                    out_valid,
  output logic [127:0]            out
);

  // Counter is sized for the larger of the round counts implied by nr and by nk.
  localparam int unsigned rnd_w = ($clog2(nr + 1) > $clog2(nk + 7)) ? $clog2(nr + 1) : $clog2(nk + 7);

  localparam logic [0:255][7:0] s_box = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [rnd_w-1:0]   rnd_q, rnd_d;
  logic [127:0]       data_q, data_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;
  logic [127:0]       round_key;
  logic [127:0]       ss_c;
  logic [127:0]       mc_c;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // SubBytes and ShiftRows fused: output byte (row r, col c) takes input byte (r, (c+r) mod 4).
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int rr = 0; rr < 4; rr++) begin
        r[127 - 8*(4*c + rr) -: 8] = s_box[s[127 - 8*(4*((c + rr) % 4) + rr) -: 8]];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [31:0]  col;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      col = s[127 - 32*c -: 32];
      a0  = col[31:24];
      a1  = col[23:16];
      a2  = col[15:8];
      a3  = col[7:0];
      r[127 - 32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                             a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                             a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                             xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return r;
  endfunction

  always_comb begin
    round_key = w[32'(rnd_q) * 32'd128 +: 128];
    ss_c      = sub_shift(data_q);
    mc_c      = mix_columns(ss_c);
  end

  // Next-state and datapath: load on accept, full rounds until nr, final round skips MixColumns.
  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          data_d  = state_in ^ w[0 +: 128];
          rnd_d   = rnd_w'(1);
          state_d = RUN;
        end
      end
      RUN: begin
        if (rnd_q == rnd_w'(nr)) begin
          data_d  = ss_c ^ round_key;
          state_d = DONE;
        end else begin
          data_d = mc_c ^ round_key;
          rnd_d  = rnd_q + rnd_w'(1);
        end
      end
      DONE: begin
        if (start) begin
          data_d  = state_in ^ w[0 +: 128];
          rnd_d   = rnd_w'(1);
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d  = (state_d == RUN);
    valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rnd_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = valid_q;
  assign out       = data_q;

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Directed-vector bench for aes_encrypt_iter with AES-128/192/256 instances sharing control inputs.
module tb_aes_encrypt_iter;

  logic         clk, reset, start;
  logic [127:0] state_in;
  logic [0:1407] w128;
  logic [0:1663] w192;
  logic [0:1919] w256;
  logic         busy128, busy192, busy256;
  logic         ov128, ov192, ov256;
  logic [127:0] out128, out192, out256;

  int passed = 0;
  int total  = 0;

  localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  localparam logic [0:255][7:0] sbox_tb = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  aes_encrypt_iter #(.nk(4), .nr(10)) dut128 (
    .clk(clk), .reset(reset), .start(start), .state_in(state_in), .w(w128),
    .busy(busy128), .out_valid(ov128), .out(out128));
  aes_encrypt_iter #(.nk(6), .nr(12)) dut192 (
    .clk(clk), .reset(reset), .start(start), .state_in(state_in), .w(w192),
    .busy(busy192), .out_valid(ov192), .out(out192));
  aes_encrypt_iter #(.nk(8), .nr(14)) dut256 (
    .clk(clk), .reset(reset), .start(start), .state_in(state_in), .w(w256),
    .busy(busy256), .out_valid(ov256), .out(out256));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox_tb[x[31:24]], sbox_tb[x[23:16]], sbox_tb[x[15:8]], sbox_tb[x[7:0]]};
  endfunction

  // Standard key expansion; the key is left-aligned in a 256-bit field.
  function automatic logic [0:1919] expand_key(input logic [255:0] key, input int nki, input int nri);
    logic [31:0]   wd [60];
    logic [31:0]   t;
    logic [7:0]    rcon;
    logic [0:1919] res;
    res  = '0;
    rcon = 8'h01;
    for (int i = 0; i < 60; i++) wd[i] = '0;
    for (int i = 0; i < 4 * (nri + 1); i++) begin
      if (i < nki) begin
        wd[i] = key[255 - 32*i -: 32];
      end else begin
        t = wd[i-1];
        if (i % nki == 0) begin
          t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
          rcon = xt(rcon);
        end else if (nki > 6 && i % nki == 4) begin
          t = sub_word(t);
        end
        wd[i] = wd[i-nki] ^ t;
      end
      res[32*i +: 32] = wd[i];
    end
    return res;
  endfunction

  logic [0:1919] xa, xb, xz, x192, x256;

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    total += 9;
    if (out128 !== 128'h0) $display("FAIL reset_out128 got %h want 0", out128); else passed++;
    if (busy128 !== 1'b0)  $display("FAIL reset_busy128 got %b want 0", busy128); else passed++;
    if (ov128 !== 1'b0)    $display("FAIL reset_valid128 got %b want 0", ov128); else passed++;
    if (out192 !== 128'h0) $display("FAIL reset_out192 got %h want 0", out192); else passed++;
    if (busy192 !== 1'b0)  $display("FAIL reset_busy192 got %b want 0", busy192); else passed++;
    if (ov192 !== 1'b0)    $display("FAIL reset_valid192 got %b want 0", ov192); else passed++;
    if (out256 !== 128'h0) $display("FAIL reset_out256 got %h want 0", out256); else passed++;
    if (busy256 !== 1'b0)  $display("FAIL reset_busy256 got %b want 0", busy256); else passed++;
    if (ov256 !== 1'b0)    $display("FAIL reset_valid256 got %b want 0", ov256); else passed++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  // All three key sizes on the same plaintext: latency, busy width, single pulse, value, hold.
  task automatic test_known_answer;
    int fv [3];
    int nv [3];
    int nb [3];
    logic [127:0] cap [3];
    for (int i = 0; i < 3; i++) begin fv[i] = -1; nv[i] = 0; nb[i] = 0; cap[i] = '0; end
    state_in = PT_A;
    start    = 1'b1;
    for (int n = 1; n <= 24; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (busy128) nb[0]++;
      if (busy192) nb[1]++;
      if (busy256) nb[2]++;
      if (ov128) begin nv[0]++; if (fv[0] < 0) begin fv[0] = n; cap[0] = out128; end end
      if (ov192) begin nv[1]++; if (fv[1] < 0) begin fv[1] = n; cap[1] = out192; end end
      if (ov256) begin nv[2]++; if (fv[2] < 0) begin fv[2] = n; cap[2] = out256; end end
    end
    total += 14;
    if (fv[0] !== 11) $display("FAIL kat128_latency got %0d want 11", fv[0]); else passed++;
    if (nb[0] !== 10) $display("FAIL kat128_busy got %0d want 10", nb[0]); else passed++;
    if (nv[0] !== 1)  $display("FAIL kat128_pulses got %0d want 1", nv[0]); else passed++;
    if (cap[0] !== CT128) $display("FAIL kat128_out got %h want %h", cap[0], CT128); else passed++;
    if (fv[1] !== 13) $display("FAIL kat192_latency got %0d want 13", fv[1]); else passed++;
    if (nb[1] !== 12) $display("FAIL kat192_busy got %0d want 12", nb[1]); else passed++;
    if (nv[1] !== 1)  $display("FAIL kat192_pulses got %0d want 1", nv[1]); else passed++;
    if (cap[1] !== CT192) $display("FAIL kat192_out got %h want %h", cap[1], CT192); else passed++;
    if (fv[2] !== 15) $display("FAIL kat256_latency got %0d want 15", fv[2]); else passed++;
    if (nb[2] !== 14) $display("FAIL kat256_busy got %0d want 14", nb[2]); else passed++;
    if (nv[2] !== 1)  $display("FAIL kat256_pulses got %0d want 1", nv[2]); else passed++;
    if (cap[2] !== CT256) $display("FAIL kat256_out got %h want %h", cap[2], CT256); else passed++;
    if (out128 !== CT128) $display("FAIL kat128_hold got %h want %h", out128, CT128); else passed++;
    if (out256 !== CT256) $display("FAIL kat256_hold got %h want %h", out256, CT256); else passed++;
  endtask

  task automatic test_ignore_start_in_run;
    int fv, nv;
    logic [127:0] cap;
    fv = -1; nv = 0; cap = '0;
    state_in = PT_A;
    start    = 1'b1;
    for (int n = 1; n <= 24; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (n == 3) begin start = 1'b1; state_in = PT_B; end
      if (n == 4) start = 1'b0;
      if (ov128) begin nv++; if (fv < 0) begin fv = n; cap = out128; end end
    end
    total += 3;
    if (fv !== 11) $display("FAIL ignore_latency got %0d want 11", fv); else passed++;
    if (nv !== 1)  $display("FAIL ignore_pulses got %0d want 1", nv); else passed++;
    if (cap !== CT128) $display("FAIL ignore_out got %h want %h", cap, CT128); else passed++;
  endtask

  // start held high; new key and plaintext presented during each DONE cycle.
  task automatic test_back_to_back;
    int pos [3];
    logic [127:0] cap [3];
    int k;
    for (int i = 0; i < 3; i++) begin pos[i] = -1; cap[i] = '0; end
    k = 0;
    w128     = xa[0:1407];
    state_in = PT_A;
    start    = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (ov128 && k < 3) begin
        pos[k] = n;
        cap[k] = out128;
        k++;
        if (k == 1) begin w128 = xb[0:1407]; state_in = PT_B; end
        if (k == 2) begin w128 = xz[0:1407]; state_in = 128'h0; end
        if (k == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    total += 6;
    if (pos[0] !== 11) $display("FAIL b2b_pos0 got %0d want 11", pos[0]); else passed++;
    if (pos[1] !== 22) $display("FAIL b2b_pos1 got %0d want 22", pos[1]); else passed++;
    if (pos[2] !== 33) $display("FAIL b2b_pos2 got %0d want 33", pos[2]); else passed++;
    if (cap[0] !== CT128) $display("FAIL b2b_out0 got %h want %h", cap[0], CT128); else passed++;
    if (cap[1] !== CT_B)  $display("FAIL b2b_out1 got %h want %h", cap[1], CT_B); else passed++;
    if (cap[2] !== CT_Z)  $display("FAIL b2b_out2 got %h want %h", cap[2], CT_Z); else passed++;
    repeat (20) @(negedge clk);
    w128 = xa[0:1407];
  endtask

  // Asynchronous reset at round 5, start ignored during reset, then a clean block.
  task automatic test_reset_mid_run;
    int nv, nbusy, fv;
    logic [127:0] cap;
    nv = 0; nbusy = 0; fv = -1; cap = '0;
    state_in = PT_A;
    start    = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
    end
    #2 reset = 1'b1;
    #1;
    total += 3;
    if (out128 !== 128'h0) $display("FAIL midrst_out got %h want 0", out128); else passed++;
    if (busy128 !== 1'b0)  $display("FAIL midrst_busy got %b want 0", busy128); else passed++;
    if (ov128 !== 1'b0)    $display("FAIL midrst_valid got %b want 0", ov128); else passed++;
    start = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (busy128 || busy256) nbusy++;
    end
    reset = 1'b0;
    start = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (ov128) nv++;
      if (busy128) nbusy++;
    end
    total += 2;
    if (nbusy !== 0) $display("FAIL start_in_reset_busy got %0d want 0", nbusy); else passed++;
    if (nv !== 0)    $display("FAIL midrst_no_valid got %0d want 0", nv); else passed++;
    start = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (ov128 && fv < 0) begin fv = n; cap = out128; end
    end
    total += 2;
    if (fv !== 11) $display("FAIL after_rst_latency got %0d want 11", fv); else passed++;
    if (cap !== CT128) $display("FAIL after_rst_out got %h want %h", cap, CT128); else passed++;
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    state_in = '0;
    xa   = expand_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
    xb   = expand_key({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4, 10);
    xz   = expand_key(256'h0, 4, 10);
    x192 = expand_key({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6, 12);
    x256 = expand_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
    w128 = xa[0:1407];
    w192 = x192[0:1663];
    w256 = x256[0:1919];
    test_reset;
    test_known_answer;
    test_ignore_start_in_run;
    test_back_to_back;
    test_reset_mid_run;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/aes_encrypt_iter.md
AES_ENCRYPT_ITER -- requirements
Module: aes_encrypt_iter

Interface
REQ-001 SHALL have parameter nk, default 4, key length in 32-bit words (4/6/8).
REQ-002 SHALL have parameter nr, default 10, round count (10/12/14, matching nk).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to encrypt state_in; sampled only when busy is low.
REQ-006 SHALL have port state_in  input  128  plaintext block.
REQ-007 SHALL have port w  input  [0:((nr+1)*128)-1]  expanded key schedule; round key k = w[(k*128)+:128].
REQ-008 SHALL have port busy  output  1  high while a block is in flight.
REQ-009 SHALL have port out_valid  output  1  one-cycle pulse marking the ciphertext on out.
REQ-010 SHALL have port out  output  128  ciphertext register.

Function
REQ-011 SHALL use FIPS-197 byte order: state byte 0 = bits [127:120], column-major; round-key bytes use the same order.
REQ-012 SHALL implement an FSM with states IDLE, RUN, DONE, a round counter rnd of width clog2(nr+1), and a 128-bit working register.
REQ-013 IDLE or DONE with start=1: working register <= state_in ^ round key 0; rnd <= 1; next state RUN.
REQ-014 IDLE with start=0: hold everything. DONE with start=0: next state IDLE.
REQ-015 RUN with rnd<nr: working register <= AddRoundKey(MixColumns(ShiftRows(SubBytes(reg))), key rnd); rnd <= rnd+1.
REQ-016 RUN with rnd==nr: working register <= AddRoundKey(ShiftRows(SubBytes(reg)), key nr); next state DONE.
REQ-017 SubBytes: forward AES S-box. MixColumns: GF(2^8) multiply with polynomial 0x11B, matrix rows {02 03 01 01} rotated.
REQ-018 busy SHALL be high exactly while the FSM is in RUN.
REQ-019 out_valid SHALL be high exactly while the FSM is in DONE, i.e. for one cycle per block.
REQ-020 out SHALL be driven from the working register and SHALL hold the last ciphertext through IDLE until the next start is accepted.
REQ-021 Latency: start sampled at edge E0 gives out_valid=1 in the cycle after edge E0+nr. Throughput: one block per nr+1 cycles with back-to-back start.
REQ-022 start while busy=1 SHALL be ignored, with no queuing and no corruption of the block in flight.
REQ-023 start asserted in the DONE cycle SHALL be accepted. out_valid still pulses for the finished block, and out changes on the next edge.
REQ-024 state_in SHALL be sampled only at the accepting edge. w SHALL be read every RUN cycle and must be held stable by the producer while busy=1.
REQ-025 Unsupported nk/nr pairs are outside scope; no error flagging is required.

Reset
REQ-026 reset=1 SHALL immediately, without waiting for a clock edge, force FSM=IDLE, rnd=0, working register=0, busy=0, out_valid=0, out=128'h0.
REQ-027 reset during RUN SHALL abort the block. No out_valid SHALL follow, and the first start after reset deassertion SHALL be processed normally.
REQ-028 start SHALL be ignored while reset=1.

Verification
REQ-029 AES-128: nk=4, nr=10, key 000102030405060708090a0b0c0d0e0f expanded into w, state_in 00112233445566778899aabbccddeeff, start for 1 cycle -> out_valid after 10 cycles, out=69c4e0d86a7b0430d8cdb78070b4c55a, busy high for exactly 10 cycles.
REQ-030 AES-256: nk=8, nr=14, key 000102…1f, same plaintext -> out=8ea2b7ca516745bfeafc49904b496089 after 14 cycles.
REQ-031 Back-to-back: start held high with the plaintext changed at each accept -> out_valid every 11 cycles (nr=10) with the correct ciphertext each time.
REQ-032 start pulsed during RUN with a different state_in -> ignored; the first result is still 69c4e0d8…c55a and no extra out_valid occurs.
REQ-033 reset asserted mid-clock at round 5 -> outputs 0 immediately, no out_valid; a fresh start afterwards yields the REQ-029 result.
REQ-034 Random plaintexts/keys against a software AES model for nk=4/6/8 -> all outputs match and out is stable between out_valid pulses.
